// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared 16-bit ALU datapath.
// A single operation is in flight at a time: accept in IDLE, compute in EXEC, hold the result in RESP.
module alu_arbiter #(
  parameter int unsigned MULDIV_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_cmd,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_cmd,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic        last_grant_r;
  logic [3:0]  cnt_r;
  logic [3:0]  cmd_r;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic        id_r;
  logic        grant_s;
  logic        accept_s;
  logic [3:0]  sel_cmd_s;
  logic [7:0]  sel_a_s;
  logic [7:0]  sel_b_s;

  // Returns {err, data}; inverting ops see zero-extended operands, so the upper byte reads 8'hFF.
  function automatic logic [16:0] alu_eval(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ae;
    logic [15:0] be;
    logic [15:0] r;
    logic        e;
    ae = {8'h00, a};
    be = {8'h00, b};
    e  = 1'b0;
    case (cmd)
      4'h0: r = ae + be;
      4'h1: r = ae - be;
      4'h2: r = ae * be;
      4'h3: begin
        if (b == 8'h00) begin
          r = 16'hFFFF;
          e = 1'b1;
        end else begin
          r = ae / be;
        end
      end
      4'h4: r = ~ae;
      4'h5: r = be + 16'd1;
      4'h6: r = be - 16'd1;
      4'h7: r = ae << 1;
      4'h8: r = be >> 1;
      4'h9: r = ae & be;
      4'hA: r = ae | be;
      4'hB: r = ~(ae & be);
      4'hC: r = ~(ae | be);
      4'hD: r = ae ^ be;
      4'hE: r = ~(ae ^ be);
      4'hF: begin
        if (b == 8'h00) begin
          r = 16'hFFFF;
          e = 1'b1;
        end else begin
          r = ae % be;
        end
      end
      default: r = 16'h0000;
    endcase
    return {e, r};
  endfunction

  function automatic logic is_long(input logic [3:0] cmd);
    return (cmd == 4'h2) || (cmd == 4'h3) || (cmd == 4'hF);
  endfunction

  // Round-robin pick: on a tie the requester that did not win last time goes next.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s   = rst_n && (state_r == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept_s && !grant_s;
  assign req1_ready = accept_s && grant_s;
  assign sel_cmd_s  = grant_s ? req1_cmd : req0_cmd;
  assign sel_a_s    = grant_s ? req1_a   : req0_a;
  assign sel_b_s    = grant_s ? req1_b   : req0_b;
  assign busy       = (state_r != IDLE);

  // Control FSM, operand capture and registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      cnt_r        <= 4'd0;
      cmd_r        <= 4'h0;
      a_r          <= 8'h00;
      b_r          <= 8'h00;
      id_r         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= 16'h0000;
      rsp_err      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cmd_r        <= sel_cmd_s;
            a_r          <= sel_a_s;
            b_r          <= sel_b_s;
            id_r         <= grant_s;
            last_grant_r <= grant_s;
            cnt_r        <= is_long(sel_cmd_s) ? 4'(MULDIV_LAT - 1) : 4'd0;
            state_r      <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          if (cnt_r == 4'd0) begin
            {rsp_err, rsp_data} <= alu_eval(cmd_r, a_r, b_r);
            rsp_id    <= id_r;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner sequences, randomized run vs reference model.
module tb_alu_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_cmd, req1_cmd;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [15:0] rsp_data;

  always #5 clk = ~clk;

  alu_arbiter #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        id;
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the zero-extended operands.
  function automatic logic [16:0] ref_alu(input logic [3:0] cmd, input int a, input int b);
    int r;
    logic e;
    e = 1'b0;
    case (cmd)
      4'h0: r = a + b;
      4'h1: r = (a - b + 65536) % 65536;
      4'h2: r = a * b;
      4'h3: if (b == 0) begin r = 65535; e = 1'b1; end else r = a / b;
      4'h4: r = 65535 - a;
      4'h5: r = b + 1;
      4'h6: r = (b + 65535) % 65536;
      4'h7: r = a * 2;
      4'h8: r = b / 2;
      4'h9: r = a & b;
      4'hA: r = a | b;
      4'hB: r = 65535 - (a & b);
      4'hC: r = 65535 - (a | b);
      4'hD: r = a ^ b;
      4'hE: r = 65535 - (a ^ b);
      4'hF: if (b == 0) begin r = 65535; e = 1'b1; end else r = a % b;
      default: r = 0;
    endcase
    return {e, r[15:0]};
  endfunction

  function automatic int lat_of(input logic [3:0] cmd);
    return (cmd == 4'h2 || cmd == 4'h3 || cmd == 4'hF) ? LAT : 1;
  endfunction

  task automatic drive(input logic id, input logic v, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid = v; req1_cmd = cmd; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_cmd = cmd; req0_a = a; req0_b = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    @(negedge clk); #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready_both", {req0_ready, req1_ready}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation from an idle DUT: immediate accept, fixed latency, then response check.
  task automatic run_op(input vec_t v, input int idx);
    int k;
    @(negedge clk);
    drive(v.id, 1'b1, v.cmd, v.a, v.b);
    drive(!v.id, 1'b0, 4'h0, 8'h00, 8'h00);
    rsp_ready = 1'b1;
    #1;
    k = 0;
    while (!(v.id ? req1_ready : req0_ready) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check($sformatf("vec%0d_accept_cycle", idx), k, 0);
    @(negedge clk);
    drive(v.id, 1'b0, v.cmd, v.a, v.b);
    #1;
    k = 1;
    while (!rsp_valid && k < 20) begin
      @(negedge clk); #1; k++;
    end
    check($sformatf("vec%0d_latency", idx), k, lat_of(v.cmd) + 1);
    check($sformatf("vec%0d_data", idx), rsp_data, v.data);
    check($sformatf("vec%0d_err", idx), rsp_err, v.err);
    check($sformatf("vec%0d_id", idx), rsp_id, v.id);
  endtask

  initial begin
    int ids [4];
    int cyc [4];
    int nacc;
    int k;

    tbl[0]  = '{1'b0, 4'h0, 8'hFF, 8'h01, 16'h0100, 1'b0};
    tbl[1]  = '{1'b0, 4'h0, 8'hA5, 8'h3C, 16'h00E1, 1'b0};
    tbl[2]  = '{1'b0, 4'h1, 8'hA5, 8'h3C, 16'h0069, 1'b0};
    tbl[3]  = '{1'b0, 4'h2, 8'hA5, 8'h3C, 16'h26AC, 1'b0};
    tbl[4]  = '{1'b0, 4'h3, 8'hA5, 8'h3C, 16'h0002, 1'b0};
    tbl[5]  = '{1'b0, 4'h4, 8'hA5, 8'h3C, 16'hFF5A, 1'b0};
    tbl[6]  = '{1'b0, 4'h5, 8'hA5, 8'h3C, 16'h003D, 1'b0};
    tbl[7]  = '{1'b0, 4'h6, 8'hA5, 8'h3C, 16'h003B, 1'b0};
    tbl[8]  = '{1'b0, 4'h7, 8'hA5, 8'h3C, 16'h014A, 1'b0};
    tbl[9]  = '{1'b0, 4'h8, 8'hA5, 8'h3C, 16'h001E, 1'b0};
    tbl[10] = '{1'b0, 4'h9, 8'hA5, 8'h3C, 16'h0024, 1'b0};
    tbl[11] = '{1'b0, 4'hA, 8'hA5, 8'h3C, 16'h00BD, 1'b0};
    tbl[12] = '{1'b0, 4'hB, 8'hA5, 8'h3C, 16'hFFDB, 1'b0};
    tbl[13] = '{1'b0, 4'hC, 8'hA5, 8'h3C, 16'hFF42, 1'b0};
    tbl[14] = '{1'b0, 4'hD, 8'hA5, 8'h3C, 16'h0099, 1'b0};
    tbl[15] = '{1'b0, 4'hE, 8'hA5, 8'h3C, 16'hFF66, 1'b0};
    tbl[16] = '{1'b0, 4'hF, 8'hA5, 8'h3C, 16'h002D, 1'b0};
    tbl[17] = '{1'b1, 4'h3, 8'h07, 8'h00, 16'hFFFF, 1'b1};
    tbl[18] = '{1'b1, 4'hF, 8'h07, 8'h03, 16'h0001, 1'b0};
    tbl[19] = '{1'b0, 4'h1, 8'h01, 8'h02, 16'hFFFF, 1'b0};

    rst_n = 1'b0; rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
    do_reset();

    for (int i = 0; i < 20; i++) run_op(tbl[i], i);

    // Continuous tie on multiplies: alternating grants, five cycles apart.
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h2, 8'h10, 8'h10);
    drive(1'b1, 1'b1, 4'h2, 8'h10, 8'h10);
    rsp_ready = 1'b1;
    nacc = 0; k = 0;
    while (nacc < 4 && k < 60) begin
      #1;
      if (rsp_valid) check("rr_data", rsp_data, 16'h0100);
      if (req0_ready || req1_ready) begin
        check("rr_onehot", req0_ready & req1_ready, 0);
        ids[nacc] = req1_ready ? 1 : 0;
        cyc[nacc] = k;
        nacc++;
      end
      @(negedge clk); k++;
    end
    check("rr_count", nacc, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), ids[i], i % 2);
    for (int i = 1; i < 4; i++) check($sformatf("rr_spacing%0d", i), cyc[i] - cyc[i-1], 5);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (8) @(negedge clk);

    // Response stall: result held, no new acceptance until the handshake.
    drive(1'b0, 1'b1, 4'h1, 8'h01, 8'h02);
    rsp_ready = 1'b0;
    #1;
    check("stall_accept", req0_ready, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 4'h0, 8'h01, 8'h01);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_data", rsp_data, 16'hFFFF);
      check("stall_req1_ready", req1_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("stall_hs_valid", rsp_valid, 1);
    check("stall_hs_req1_ready", req1_ready, 0);
    @(negedge clk); #1;
    check("stall_after_req1_ready", req1_ready, 1);
    check("stall_after_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (6) @(negedge clk);

    // Reset during EXEC drops the operation and restores req0 priority.
    drive(1'b1, 1'b1, 4'h0, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b1, 4'h2, 8'h10, 8'h10);
    #1;
    check("rexec_accept", req0_ready, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    #1;
    check("rexec_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rexec_busy_after", busy, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check("rexec_no_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h0, 8'h01, 8'h01);
    drive(1'b1, 1'b1, 4'h0, 8'h02, 8'h02);
    #1;
    check("rexec_tie_req0", req0_ready, 1);
    check("rexec_tie_req1", req1_ready, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
    repeat (6) @(negedge clk);

    // Randomized traffic vs reference model.
    begin
      logic        rv [2];
      logic [3:0]  rc [2];
      logic [7:0]  ra [2];
      logic [7:0]  rb [2];
      logic        took [2];
      logic        in_flight;
      int          acc_cyc, hs_cyc, exp_last, n_done, win;
      logic [16:0] exp_rsp;
      logic        exp_id;
      logic        exp_acc, exp_valid;
      for (int j = 0; j < 2; j++) begin rv[j] = 1'b0; took[j] = 1'b0; end
      in_flight = 1'b0; acc_cyc = 0; hs_cyc = -1; exp_last = 1; n_done = 0;
      exp_rsp = 17'h0; exp_id = 1'b0;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
          if (!rv[j] || took[j]) begin
            rv[j] = ($urandom_range(0, 2) != 0);
            rc[j] = 4'($urandom_range(0, 15));
            ra[j] = 8'($urandom);
            rb[j] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
          end
          drive(j[0], rv[j], rc[j], ra[j], rb[j]);
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        exp_acc = !in_flight && (c > hs_cyc) && (rv[0] || rv[1]);
        win = (rv[0] && rv[1]) ? 1 - exp_last : (rv[1] ? 1 : 0);
        check("rnd_ready0", req0_ready, exp_acc && win == 0);
        check("rnd_ready1", req1_ready, exp_acc && win == 1);
        check("rnd_busy", busy, in_flight);
        exp_valid = in_flight && (c >= acc_cyc + lat_of(exp_rsp[16] ? 4'h3 : 4'h0) * 0 + acc_lat(0));
        took[0] = req0_ready;
        took[1] = req1_ready;
        if (in_flight) begin
          check("rnd_rsp_valid", rsp_valid, (c >= acc_cyc) ? 1 : 0);
        end else begin
          check("rnd_rsp_valid_idle", rsp_valid, 0);
        end
        if (rsp_valid && in_flight) begin
          check("rnd_data", rsp_data, exp_rsp[15:0]);
          check("rnd_err", rsp_err, exp_rsp[16]);
          check("rnd_id", rsp_id, exp_id);
          if (rsp_ready) begin
            in_flight = 1'b0;
            hs_cyc = c;
            n_done++;
          end
        end
        if (req0_ready || req1_ready) begin
          exp_id   = req1_ready;
          exp_last = req1_ready ? 1 : 0;
          exp_rsp  = ref_alu(rc[exp_id], ra[exp_id], rb[exp_id]);
          acc_cyc  = c + lat_of(rc[exp_id]) + 1;
          in_flight = 1'b1;
        end
      end
      check("rnd_progress", (n_done > 200) ? 1 : 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic int acc_lat(input int x);
    return x;
  endfunction

endmodule
